// File: rtl/trace_pkg.sv
// Shared definitions for the pipeline trace buffer: FSM encoding and parameter legality helpers.
package trace_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRE     = 3'd1,
    ARMED   = 3'd2,
    POST    = 3'd3,
    READOUT = 3'd4
  } state_t;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit depth_ok(input int unsigned depth);
    return is_pow2(depth) && (depth >= 4);
  endfunction

  function automatic bit pre_trig_ok(input int unsigned pre, input int unsigned depth);
    return (pre >= 1) && (pre + 2 <= depth);
  endfunction

endpackage

// File: rtl/trace_mem.sv
// Sample storage: one synchronous write port and one registered, enable-gated read port.
module trace_mem #(
  parameter  int unsigned DEPTH = 64,
  parameter  int unsigned DW    = 128,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // Array itself is never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pipe_trace_buffer.sv
// Triggered logic-analyser style trace buffer: circular pre/post-trigger capture, then
// in-order readout of DEPTH samples starting PRE_TRIG samples before the trigger.
module pipe_trace_buffer
  import trace_pkg::*;
#(
  parameter  int unsigned CH       = 4,
  parameter  int unsigned W        = 32,
  parameter  int unsigned DEPTH    = 64,
  parameter  int unsigned PRE_TRIG = 16,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            arm,
  input  logic            abort,
  input  logic            trig,
  input  logic            smp_valid,
  input  logic [CH*W-1:0] smp_data,
  input  logic [CH-1:0]   ch_mask,
  input  logic            rd_ready,
  output logic            rd_valid,
  output logic [CH*W-1:0] rd_data,
  output logic            rd_last,
  output logic [2:0]      state,
  output logic [AW-1:0]   trig_pos
);

  localparam int unsigned DW = CH * W;
  localparam logic [AW-1:0] PRE_LEN   = AW'(PRE_TRIG);
  localparam logic [AW-1:0] PRE_LAST  = AW'(PRE_TRIG - 1);
  localparam logic [AW-1:0] POST_LEN  = AW'(DEPTH - PRE_TRIG - 1);
  localparam logic [AW-1:0] LAST_BEAT = AW'(DEPTH - 1);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("pipe_trace_buffer: DEPTH must be a power of two and at least 4");
  end
  if (!pre_trig_ok(PRE_TRIG, DEPTH)) begin : g_bad_pre_trig
    $error("pipe_trace_buffer: PRE_TRIG must lie in 1..DEPTH-2");
  end

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr, rd_ptr, fill_cnt, post_cnt, beat_cnt;
  logic          wr_en_c, rd_en_c, trig_hit_c, arm_hit_c, beat_done_c;
  logic [DW-1:0] wr_data_c;

  assign state = state_q;

  // Masked channels are stored as zeros, so later mask changes cannot affect stored data.
  always_comb begin
    wr_data_c = '0;
    for (int c = 0; c < int'(CH); c++) begin
      if (ch_mask[c]) wr_data_c[c*W +: W] = smp_data[c*W +: W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state plus per-cycle strobes; abort overrides everything else.
  always_comb begin
    state_d     = state_q;
    wr_en_c     = 1'b0;
    rd_en_c     = 1'b0;
    trig_hit_c  = 1'b0;
    arm_hit_c   = 1'b0;
    beat_done_c = rd_valid && rd_ready;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (arm) begin
            arm_hit_c = 1'b1;
            state_d   = PRE;
          end
        end
        PRE: begin
          wr_en_c = smp_valid;
          if (smp_valid && (fill_cnt == PRE_LAST)) state_d = ARMED;
        end
        ARMED: begin
          wr_en_c = smp_valid;
          if (smp_valid && trig) begin
            trig_hit_c = 1'b1;
            state_d    = (POST_LEN == '0) ? READOUT : POST;
          end
        end
        POST: begin
          if (post_cnt == '0) begin
            state_d = READOUT;
          end else if (smp_valid) begin
            wr_en_c = 1'b1;
            if (post_cnt == AW'(1)) state_d = READOUT;
          end
        end
        READOUT: begin
          // Prefetch the first beat on entry, then the next beat as each one is accepted.
          rd_en_c = !rd_valid || (beat_done_c && !rd_last);
          if (beat_done_c && rd_last) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill_cnt <= '0;
      post_cnt <= '0;
      beat_cnt <= '0;
      trig_pos <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      if (arm_hit_c) begin
        wr_ptr   <= '0;
        fill_cnt <= '0;
        beat_cnt <= '0;
      end
      if (wr_en_c) wr_ptr <= wr_ptr + AW'(1);
      if (wr_en_c && (state_q == PRE)) fill_cnt <= fill_cnt + AW'(1);
      // Readout start is fixed at trigger time, so it is computed here once.
      if (trig_hit_c) begin
        trig_pos <= wr_ptr;
        rd_ptr   <= wr_ptr - PRE_LEN;
        post_cnt <= POST_LEN;
        beat_cnt <= '0;
      end else if (wr_en_c && (state_q == POST)) begin
        post_cnt <= post_cnt - AW'(1);
      end
      if (rd_en_c) begin
        rd_ptr   <= rd_ptr + AW'(1);
        beat_cnt <= beat_cnt + AW'(1);
        rd_valid <= 1'b1;
        rd_last  <= (beat_cnt == LAST_BEAT);
      end
      if (abort || (beat_done_c && rd_last)) begin
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end
    end
  end

  trace_mem #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en_c),
    .wr_addr (wr_ptr),
    .wr_data (wr_data_c),
    .rd_en   (rd_en_c),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

endmodule
